// File: rtl/zbt_port_arbiter.sv
// ZBT SRAM port arbiter: display reads win every cycle, camera writes are buffered.
// Build option ZBT_ARB_DROPCNT_EN adds a saturating dropped-write counter.
module zbt_port_arbiter #(
  parameter int DEPTH = 8,
  parameter int AW    = 19,
  parameter int DW    = 36
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ntsc_we,
  input  logic [AW-1:0] ntsc_addr,
  input  logic [DW-1:0] ntsc_data,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  output logic          fifo_empty,
  output logic          overflow,
  output logic [15:0]   drop_count,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we_b,
  output logic [DW-1:0] ram_data_out,
  output logic          ram_data_oe,
  input  logic [DW-1:0] ram_data_in
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fa [DEPTH];
  logic [DW-1:0] fd [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          wd1_v;
  logic          wd2_v;
  logic [DW-1:0] wd1_d;
  logic [DW-1:0] wd2_d;
  logic [2:0]    rd_pipe;

  // Reads win; a write drains only when the bus is free and data is queued
  always_comb begin
    full     = (count == CW'(DEPTH));
    pop      = !disp_req && (count != '0);
    push     = ntsc_we && (!full || pop);
    drop     = ntsc_we && full && !pop;
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  // FIFO storage; contents are qualified by the count and need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wr_ptr] <= ntsc_addr;
      fd[wr_ptr] <= ntsc_data;
    end
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_nx;
      fifo_empty <= (count_nx == '0);
      if (drop) overflow <= 1'b1;
    end
  end

  // Command slot on the ZBT pins; address holds when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr <= '0;
      ram_we_b <= 1'b1;
    end else if (disp_req) begin
      ram_addr <= disp_addr;
      ram_we_b <= 1'b1;
    end else if (pop) begin
      ram_addr <= fa[rd_ptr];
      ram_we_b <= 1'b0;
    end else begin
      ram_we_b <= 1'b1;
    end
  end

  // Write data trails its command by two cycles to hit the ZBT data slot
  always_ff @(posedge clk) begin
    if (reset) begin
      wd1_v        <= 1'b0;
      wd2_v        <= 1'b0;
      wd1_d        <= '0;
      wd2_d        <= '0;
      ram_data_oe  <= 1'b0;
      ram_data_out <= '0;
    end else begin
      wd1_v       <= pop;
      wd1_d       <= fd[rd_ptr];
      wd2_v       <= wd1_v;
      wd2_d       <= wd1_d;
      ram_data_oe <= wd2_v;
      if (wd2_v) ram_data_out <= wd2_d;
    end
  end

  // Read data is captured three edges after the request was accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe    <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      rd_pipe    <= {rd_pipe[1:0], disp_req};
      disp_valid <= rd_pipe[2];
      if (rd_pipe[2]) disp_data <= ram_data_in;
    end
  end

`ifdef ZBT_ARB_DROPCNT_EN
  logic [15:0] drop_q;

  // Saturating count of camera writes lost to a full FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Randomized bench for zbt_port_arbiter against a queue-based reference model.
// Define ZBT_ARB_DROPCNT_EN here too when building the counter variant.
module tb_zbt_port_arbiter;

  localparam int DEPTH = 8;
  localparam int AW    = 19;
  localparam int DW    = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic          ntsc_we;
  logic [AW-1:0] ntsc_addr;
  logic [DW-1:0] ntsc_data;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          fifo_empty;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [AW-1:0] ram_addr;
  logic          ram_we_b;
  logic [DW-1:0] ram_data_out;
  logic          ram_data_oe;
  logic [DW-1:0] ram_data_in;

  always #5 clk = ~clk;

  zbt_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ntsc_we(ntsc_we), .ntsc_addr(ntsc_addr), .ntsc_data(ntsc_data),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .fifo_empty(fifo_empty), .overflow(overflow),
    .drop_count(drop_count),
    .ram_addr(ram_addr), .ram_we_b(ram_we_b),
    .ram_data_out(ram_data_out), .ram_data_oe(ram_data_oe),
    .ram_data_in(ram_data_in)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  bit            exp_oe[int];
  logic [DW-1:0] exp_wd[int];
  bit            exp_v[int];
  logic [DW-1:0] exp_rd[int];
  logic [AW-1:0] m_addr;
  logic          m_web;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_ddata;
  logic          m_ovf;
  int            m_drops;
  logic [AW-1:0] p1a, p2a;
  logic          p1r, p2r;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] hsh(input logic [AW-1:0] a);
    return {a[16:0], a} ^ 36'h5A5A5A5A5;
  endfunction

  // Reference: reads issue immediately, writes queue and drain in free slots
  task automatic model();
    wr_t w;
    if (reset) begin
      q.delete();
      m_addr  = '0;
      m_web   = 1'b1;
      m_dout  = '0;
      m_ddata = '0;
      m_ovf   = 1'b0;
      m_drops = 0;
      for (int k = cyc; k < cyc + 4; k++) begin
        exp_oe.delete(k);
        exp_v.delete(k);
      end
    end else begin
      if (disp_req) begin
        m_addr = disp_addr;
        m_web  = 1'b1;
        exp_v[cyc + 3]  = 1'b1;
        exp_rd[cyc + 3] = hsh(disp_addr);
      end else if (q.size() > 0) begin
        w      = q.pop_front();
        m_addr = w.a;
        m_web  = 1'b0;
        exp_oe[cyc + 2] = 1'b1;
        exp_wd[cyc + 2] = w.d;
      end else begin
        m_web = 1'b1;
      end
      if (ntsc_we) begin
        if (q.size() < DEPTH) begin
          w.a = ntsc_addr;
          w.d = ntsc_data;
          q.push_back(w);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (exp_oe.exists(cyc)) m_dout = exp_wd[cyc];
      if (exp_v.exists(cyc)) m_ddata = exp_rd[cyc];
    end
  endtask

  task automatic check_outputs();
    int exp_drop;
`ifdef ZBT_ARB_DROPCNT_EN
    exp_drop = m_drops;
`else
    exp_drop = 0;
`endif
    chk("ram_addr", 64'(ram_addr), 64'(m_addr));
    chk("ram_we_b", 64'(ram_we_b), 64'(m_web));
    chk("ram_data_oe", 64'(ram_data_oe), 64'(exp_oe.exists(cyc)));
    chk("ram_data_out", 64'(ram_data_out), 64'(m_dout));
    chk("disp_valid", 64'(disp_valid), 64'(exp_v.exists(cyc)));
    chk("disp_data", 64'(disp_data), 64'(m_ddata));
    chk("fifo_empty", 64'(fifo_empty), 64'(q.size() == 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(exp_drop));
  endtask

  task automatic step(input bit rst, input bit dreq, input logic [AW-1:0] da,
                      input bit we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
    @(negedge clk);
    reset     = rst;
    disp_req  = dreq;
    disp_addr = da;
    ntsc_we   = we;
    ntsc_addr = wa;
    ntsc_data = wd;
    cyc++;
    model();
    @(posedge clk);
    #1;
    // SRAM: read data appears on the bus two cycles after its command
    ram_data_in = p2r ? hsh(p2a) : DW'({$urandom(), $urandom()});
    p2a = p1a;
    p2r = p1r;
    p1a = ram_addr;
    p1r = ram_we_b;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  function automatic logic [AW-1:0] ra();
    return AW'($urandom());
  endfunction

  function automatic logic [DW-1:0] rd();
    return DW'({$urandom(), $urandom()});
  endfunction

  initial begin
    int dp;
    reset = 1'b1;
    disp_req = 1'b0;
    disp_addr = '0;
    ntsc_we = 1'b0;
    ntsc_addr = '0;
    ntsc_data = '0;
    ram_data_in = '0;
    p1a = '0;
    p2a = '0;
    p1r = 1'b0;
    p2r = 1'b0;
    m_addr = '0;
    m_web = 1'b1;
    m_dout = '0;
    m_ddata = '0;
    m_ovf = 1'b0;
    m_drops = 0;

    rst_cycles(2);
    step(1'b0, 1'b1, 19'h00010, 1'b0, '0, '0);
    idle(5);
    step(1'b0, 1'b0, '0, 1'b1, 19'h00100, 36'h12345678);
    idle(5);

    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, ra(), (i == 3 || i == 8 || i == 13), ra(), rd());
    idle(6);

    rst_cycles(1);
    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b0, 1'b1, ra(), 1'b1, ra(), rd());
    idle(DEPTH + 4);

    rst_cycles(1);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, ra(), 1'b1, ra(), rd());
    step(1'b0, 1'b0, '0, 1'b1, ra(), rd());
    idle(DEPTH + 4);

    step(1'b0, 1'b1, ra(), 1'b1, ra(), rd());
    rst_cycles(1);
    idle(5);

    dp = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) dp = (($urandom_range(0, 2) == 0) ? 95 :
                             ($urandom_range(0, 1) == 0) ? 60 : 15);
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < dp), ra(),
           ($urandom_range(0, 99) < 45), ra(), rd());
    end
    idle(DEPTH + 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
